parity_frame_tx: RTL and testbench



---
 rtl/parity_tx_pkg.sv | 20 ++
 rtl/ParityGenerator.sv | 11 +
 rtl/parity_frame_tx.sv | 145 ++++++++++++++
 tb/tb_parity_frame_tx.sv | 124 ++++++++++++
 4 files changed

// File: rtl/parity_tx_pkg.sv
// parity_tx_pkg: shared types and constants for the parity frame transmitter
package parity_tx_pkg;

    localparam int DATA_W          = 16;
    localparam int FRAME_DATA_BITS = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    // Busy cycles of one frame: start bit, data bits, parity bit, stop bits.
    function automatic int frame_cycles(int clks_per_bit, int stop_bits);
        return (2 + FRAME_DATA_BITS + stop_bits) * clks_per_bit;
    endfunction

endpackage

// File: rtl/ParityGenerator.sv
// ParityGenerator: XOR reduction of a data word (1 = odd number of ones)
module ParityGenerator #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a_i,
    output logic             parity_o
);

    assign parity_o = ^a_i;

endmodule

// File: rtl/parity_frame_tx.sv
// parity_frame_tx: serialises a 16-bit word as start, LSB-first data, parity, stop bits.
// Optional macro PARITY_TX_ODD_PARITY_EN selects odd parity instead of even.
module parity_frame_tx
    import parity_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic              tx_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int CW = $clog2(CLKS_PER_BIT * 2 + 1);
    localparam int BW = $clog2(FRAME_DATA_BITS);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(FRAME_DATA_BITS - 1);
`ifdef PARITY_TX_ODD_PARITY_EN
    localparam logic ODD = 1'b1;
`else
    localparam logic ODD = 1'b0;
`endif

    state_t            state_q, state_d;
    logic [CW-1:0]     cyc_q, cyc_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_q, par_d;
    logic              tx_q, tx_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              gen_par;
    logic              accept;
    logic              cyc_last;

    ParityGenerator #(.WIDTH(DATA_W)) u_par (
        .a_i      (data_i),
        .parity_o (gen_par)
    );

    assign accept   = valid_i & ready_q;
    assign cyc_last = (cyc_q == '0);

    // Next state, counters and datapath; outputs follow the next state so they are registered.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = START;
                    cyc_d   = BIT_LAST;
                    bit_d   = '0;
                    shift_d = data_i;
                    par_d   = gen_par ^ ODD;
                end
            end
            START: begin
                if (cyc_last) begin
                    state_d = DATA;
                    cyc_d   = BIT_LAST;
                end else begin
                    cyc_d = cyc_q - CW'(1);
                end
            end
            DATA: begin
                if (cyc_last) begin
                    cyc_d = BIT_LAST;
                    if (bit_q == LAST_BIT) begin
                        state_d = PARITY;
                    end else begin
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q + BW'(1);
                    end
                end else begin
                    cyc_d = cyc_q - CW'(1);
                end
            end
            PARITY: begin
                if (cyc_last) begin
                    state_d = STOP;
                    cyc_d   = STOP_LAST;
                end else begin
                    cyc_d = cyc_q - CW'(1);
                end
            end
            STOP: begin
                if (cyc_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    cyc_d = cyc_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        tx_d    = (state_d == START)  ? 1'b0 :
                  (state_d == DATA)   ? shift_d[0] :
                  (state_d == PARITY) ? par_d : 1'b1;
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    // State and output registers; reset drops any frame and idles the line at once.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign ready_o = ready_q;
    assign tx_o    = tx_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

endmodule

// File: tb/tb_parity_frame_tx.sv
// tb_parity_frame_tx: directed frame checks for parity_frame_tx (CLKS_PER_BIT=4, STOP_BITS=1)
module tb_parity_frame_tx;

    localparam int C  = 4;
    localparam int FC = 76;
`ifdef PARITY_TX_ODD_PARITY_EN
    localparam logic ODD = 1'b1;
`else
    localparam logic ODD = 1'b0;
`endif

    typedef struct {
        logic [15:0] data;
        logic        par;
        logic        hold;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic [15:0] data_i = '0;
    logic        valid_i = 1'b0;
    logic        ready_o, tx_o, busy_o, done_o;
    int          checks = 0;
    int          failures = 0;

    parity_frame_tx #(.CLKS_PER_BIT(C), .STOP_BITS(1)) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .data_i  (data_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .tx_o    (tx_o),
        .busy_o  (busy_o),
        .done_o  (done_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge with ready_o=1; returns at the negedge of the done cycle.
    task automatic send_frame(input logic [15:0] d, input logic par, input logic hold, input logic scramble);
        logic [18:0] frame;
        frame = {1'b1, par, d, 1'b0};
        data_i  = d;
        valid_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!hold) valid_i = 1'b0;
        if (scramble) data_i = 16'hFFFF;
        for (int k = 0; k < FC; k++) begin
            check($sformatf("tx d=%h cyc=%0d", d, k), {31'd0, tx_o}, {31'd0, frame[k / C]});
            check($sformatf("flags d=%h cyc=%0d", d, k), {29'd0, busy_o, ready_o, done_o}, 32'b100);
            @(negedge clk);
        end
        check($sformatf("done cycle d=%h", d), {28'd0, tx_o, busy_o, ready_o, done_o}, 32'b1011);
    endtask

    initial begin
        vec_t vecs[8];
        vecs[0] = '{16'h0000, 1'b0 ^ ODD, 1'b0};
        vecs[1] = '{16'h0001, 1'b1 ^ ODD, 1'b0};
        vecs[2] = '{16'hFFFF, 1'b0 ^ ODD, 1'b0};
        vecs[3] = '{16'h8001, 1'b0 ^ ODD, 1'b0};
        vecs[4] = '{16'h0007, 1'b1 ^ ODD, 1'b0};
        vecs[5] = '{16'hA5A5, 1'b0 ^ ODD, 1'b1};
        vecs[6] = '{16'h0F0F, 1'b0 ^ ODD, 1'b1};
        vecs[7] = '{16'h1234, 1'b1 ^ ODD, 1'b0};

        #1 rst_i = 1'b1;
        #1 check("reset outputs", {28'd0, tx_o, busy_o, ready_o, done_o}, 32'b1010);
        @(negedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        check("idle after reset", {28'd0, tx_o, busy_o, ready_o, done_o}, 32'b1010);

        for (int i = 0; i < 8; i++) begin
            send_frame(vecs[i].data, vecs[i].par, vecs[i].hold, 1'b0);
        end
        valid_i = 1'b0;
        @(negedge clk);
        check("idle between frames", {28'd0, tx_o, busy_o, ready_o, done_o}, 32'b1010);

        send_frame(16'h0000, 1'b0 ^ ODD, 1'b0, 1'b1);
        @(negedge clk);

        data_i  = 16'h0F0F;
        valid_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0;
        repeat (34) @(negedge clk);
        check("tx bit7 before abort", {31'd0, tx_o}, 32'd0);
        check("busy before abort", {31'd0, busy_o}, 32'd1);
        #1 rst_i   = 1'b1;
        valid_i = 1'b1;
        #1 check("async abort", {28'd0, tx_o, busy_o, ready_o, done_o}, 32'b1010);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("held in reset", {28'd0, tx_o, busy_o, ready_o, done_o}, 32'b1010);
        end
        valid_i = 1'b0;
        rst_i   = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("no accept or done after abort", {28'd0, tx_o, busy_o, ready_o, done_o}, 32'b1010);
        end

        send_frame(16'h0003, 1'b0 ^ ODD, 1'b0, 1'b0);
        @(negedge clk);
        check("final idle", {28'd0, tx_o, busy_o, ready_o, done_o}, 32'b1010);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
